sdm2: RTL and testbench

- Second-order delta-sigma modulator; converts signed PCM samples into the 1-bit PDM stream consumed by the cic decimator's `din`.
- Sits directly upstream of cic, in both the test harness and the loopback path.
- Accepts one PCM sample per OSR clocks over a valid/ready handshake and emits one PDM bit per clock.

---
 rtl/sdm2_pkg.sv | 32 +++
 rtl/sdm2_core.sv | 68 ++++++
 rtl/sdm2.sv | 79 +++++++
 tb/tb_sdm2.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sdm2_pkg.sv
// sdm2_pkg: shared constants and saturation helper for the second-order
// delta-sigma modulator (sdm2). The SDM2_DITHER_EN macro selects the LFSR
// dither in sdm2_core; the constants for it live here in both builds.
package sdm2_pkg;

    localparam int DW_DEF  = 16;
    localparam int IW_DEF  = DW_DEF + 4;
    localparam int OSR_DEF = 64;

    // Full-scale feedback magnitude and integrator clamp for the default widths
    localparam int FS_DEF      = 2 ** (DW_DEF - 1);
    localparam int SAT_POS_DEF = 2 ** (IW_DEF - 2);
    localparam int SAT_NEG_DEF = -(2 ** (IW_DEF - 2));

    // 16-bit Fibonacci LFSR, taps 16,14,13,11 expressed as bit mask 15,13,12,10
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Clamp a wide signed value to +/-2^(iw-2) so an iw-bit integrator never wraps
    function automatic logic signed [63:0] sdm2_sat(input logic signed [63:0] x,
                                                    input int iw);
        logic signed [63:0] lim;
        lim = 64'sd1 <<< (iw - 2);
        if (x > lim)
            return lim;
        else if (x < -lim)
            return -lim;
        else
            return x;
    endfunction

endpackage

// File: rtl/sdm2_core.sv
// sdm2_core: two saturating integrators and a 1-bit quantizer with registered
// output. Build macro SDM2_DITHER_EN adds a 16-bit LFSR whose low nibble
// (-8..+7) is added to the second integrator before the sign test.
module sdm2_core
    import sdm2_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int IW = DW + 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [DW-1:0] cur,
    output logic                 dout
);

    localparam logic signed [63:0] FS = 64'sd1 <<< (DW - 1);

    logic signed [IW-1:0] i1;
    logic signed [IW-1:0] i2;
    logic signed [IW-1:0] i1_n;
    logic signed [IW-1:0] i2_n;
    logic signed [63:0]   f_w;
    logic signed [63:0]   s1_w;
    logic signed [63:0]   s2_w;
    logic signed [63:0]   q_w;
    logic                 dout_n;

`ifdef SDM2_DITHER_EN
    logic [15:0] lfsr;

    // LFSR advances every clock; feedback is the XOR of the tapped bits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            lfsr <= LFSR_SEED;
        else
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end
`endif

    // Integrator updates with feedback chosen by the previous output bit
    always_comb begin
        f_w    = dout ? FS : -FS;
        s1_w   = sdm2_sat(64'(i1) + 64'(cur) - f_w, IW);
        i1_n   = s1_w[IW-1:0];
        s2_w   = sdm2_sat(64'(i2) + s1_w - f_w, IW);
        i2_n   = s2_w[IW-1:0];
`ifdef SDM2_DITHER_EN
        q_w    = s2_w + 64'(signed'(lfsr[3:0]));
`else
        q_w    = s2_w;
`endif
        dout_n = (q_w >= 0);
    end

    // Integrator state and quantized output bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i1   <= '0;
            i2   <= '0;
            dout <= 1'b0;
        end else begin
            i1   <= i1_n;
            i2   <= i2_n;
            dout <= dout_n;
        end
    end

endmodule

// File: rtl/sdm2.sv
// sdm2: second-order delta-sigma modulator, PCM in over valid/ready, one PDM
// bit per clock out. One-deep `nxt` buffer feeds `cur` at each period wrap.
// Build macro SDM2_DITHER_EN enables LFSR dither inside sdm2_core.
module sdm2
    import sdm2_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int OSR = OSR_DEF,
    parameter int IW  = DW + 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [DW-1:0] pcm,
    input  logic                 pcm_valid,
    output logic                 pcm_ready,
    output logic                 dout,
    output logic                 underrun,
    output logic                 tick
);

    localparam int              CW   = (OSR > 2) ? $clog2(OSR) : 1;
    localparam logic [CW-1:0]   LAST = CW'(OSR - 1);

    logic [CW-1:0]        cnt;
    logic                 next_full;
    logic signed [DW-1:0] nxt;
    logic signed [DW-1:0] cur;
    logic                 wrap;
    logic                 xfer;

    assign pcm_ready = !next_full;
    assign wrap      = (cnt == LAST);
    assign xfer      = pcm_valid && pcm_ready;

    // Sample-period counter, 0..OSR-1
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else
            cnt <= wrap ? '0 : cnt + CW'(1);
    end

    // Buffer: consume on wrap when full, otherwise capture on a transfer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            next_full <= 1'b0;
            nxt       <= '0;
            cur       <= '0;
        end else if (wrap && next_full) begin
            cur       <= nxt;
            next_full <= 1'b0;
        end else if (xfer) begin
            nxt       <= pcm;
            next_full <= 1'b1;
        end
    end

    // Period-boundary pulses; underrun judged on the buffer state at the wrap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            tick     <= wrap;
            underrun <= wrap && !next_full;
        end
    end

    sdm2_core #(
        .DW (DW),
        .IW (IW)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .cur   (cur),
        .dout  (dout)
    );

endmodule

// File: tb/tb_sdm2.sv
// tb_sdm2: table-driven density/underrun checks, hand-written corner sequences
// and randomized traffic, all compared cycle by cycle against a plain
// arithmetic model of the modulator kept in this bench.
module tb_sdm2;

    localparam int DW  = 16;
    localparam int OSR = 64;
    localparam int IW  = DW + 4;
    localparam longint FS  = 64'sd1 <<< (DW - 1);
    localparam longint LIM = 64'sd1 <<< (IW - 2);

    logic                 clk;
    logic                 reset = 1'b1;
    logic signed [DW-1:0] pcm = '0;
    logic                 pcm_valid = 1'b0;
    logic                 pcm_ready;
    logic                 dout;
    logic                 underrun;
    logic                 tick;

    sdm2 #(.DW(DW), .OSR(OSR), .IW(IW)) dut (
        .clk       (clk),
        .reset     (reset),
        .pcm       (pcm),
        .pcm_valid (pcm_valid),
        .pcm_ready (pcm_ready),
        .dout      (dout),
        .underrun  (underrun),
        .tick      (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference model state
    int       m_cnt;
    longint   m_i1, m_i2, m_cur;
    bit       m_dout, m_tick, m_und;
    longint   mq[$];
    bit [15:0] m_lfsr;

    // running statistics
    int ones, unds, ticks, readys;
    bit last_xfer;

    typedef struct {
        int pcm;
        bit one_shot;
        int settle;
        int window;
        int lo;
        int hi;
        int und_exp;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic chk_range(input string nm, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    function automatic longint clampv(input longint x);
        if (x > LIM) return LIM;
        if (x < -LIM) return -LIM;
        return x;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_i1 = 0; m_i2 = 0; m_cur = 0;
        m_dout = 0; m_tick = 0; m_und = 0;
        mq.delete();
        m_lfsr = 16'hACE1;
    endtask

    // one clock of the reference: modulator equations plus a 1-entry queue
    task automatic model_clock();
        longint f, a1, a2, q;
        bit wrap, xf;
        int d;
        f  = m_dout ? FS : -FS;
        a1 = clampv(m_i1 + m_cur - f);
        a2 = clampv(m_i2 + a1 - f);
        q  = a2;
`ifdef SDM2_DITHER_EN
        d = int'(m_lfsr[3:0]);
        if (d > 7) d -= 16;
        q += d;
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`else
        d = 0;
`endif
        m_i1 = a1; m_i2 = a2;
        m_dout = (q >= 0);
        wrap = (m_cnt == OSR - 1);
        xf   = pcm_valid && (mq.size() == 0);
        m_tick = wrap;
        m_und  = wrap && (mq.size() == 0);
        if (wrap && mq.size() > 0)
            m_cur = mq.pop_front();
        else if (xf)
            mq.push_back(longint'(pcm));
        m_cnt = wrap ? 0 : m_cnt + 1;
    endtask

    task automatic step();
        last_xfer = pcm_valid && pcm_ready;
        @(posedge clk);
        model_clock();
        #1;
        chk("dout", dout, m_dout);
        chk("tick", tick, m_tick);
        chk("underrun", underrun, m_und);
        chk("pcm_ready", pcm_ready, mq.size() == 0);
        ones   += dout;
        unds   += underrun;
        ticks  += tick;
        readys += pcm_ready;
    endtask

    task automatic clr_stats();
        ones = 0; unds = 0; ticks = 0; readys = 0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        #1;
        model_reset();
        chk("rst_dout", dout, 1'b0);
        chk("rst_tick", tick, 1'b0);
        chk("rst_underrun", underrun, 1'b0);
        chk("rst_pcm_ready", pcm_ready, 1'b1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk("rst_hold_dout", dout, 1'b0);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    vec_t tbl[3];
    int   cnt_to_tick;
    bit   seen;
    int   nx;

    initial begin
        tbl[0] = '{pcm: 0,      one_shot: 1'b0, settle: 64,  window: 1024, lo: 508,  hi: 516,  und_exp: 0};
        tbl[1] = '{pcm: 16384,  one_shot: 1'b0, settle: 128, window: 4096, lo: 3031, hi: 3113, und_exp: 0};
        tbl[2] = '{pcm: -16384, one_shot: 1'b1, settle: 192, window: 4096, lo: 983,  hi: 1065, und_exp: 64};

        #2;
        // table-driven density / underrun vectors
        for (int r = 0; r < 3; r++) begin
            pcm_valid = 1'b0;
            do_reset(2);
            pcm = DW'(tbl[r].pcm);
            pcm_valid = 1'b1;
            for (int i = 0; i < tbl[r].settle; i++) begin
                step();
                if (tbl[r].one_shot && last_xfer) pcm_valid = 1'b0;
            end
            clr_stats();
            for (int i = 0; i < tbl[r].window; i++) step();
            chk_range($sformatf("density_row%0d", r), ones, tbl[r].lo, tbl[r].hi);
            chk($sformatf("underruns_row%0d", r), unds, tbl[r].und_exp);
            chk($sformatf("ticks_row%0d", r), ticks, tbl[r].window / OSR);
        end

        // backpressure: valid always high, new value offered after each transfer
        pcm_valid = 1'b0;
        do_reset(2);
        clr_stats();
        nx = 0;
        pcm = DW'(-12000);
        pcm_valid = 1'b1;
        for (int i = 0; i < 20 * OSR; i++) begin
            step();
            if (last_xfer) begin
                nx++;
                pcm = DW'(-12000 + 1500 * nx);
            end
        end
        chk("bp_transfers", nx, 20);
        chk("bp_ready_cycles", readys, 20);
        chk("bp_underruns", unds, 0);

        // mid-period reset at cnt=30, then first tick 64 clocks after release
        pcm = DW'(8000);
        pcm_valid = 1'b1;
        do_reset(2);
        for (int i = 0; i < 30; i++) step();
        do_reset(2);
        cnt_to_tick = 0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            step();
            cnt_to_tick++;
            if (tick) seen = 1'b1;
        end
        chk("first_tick_seen", seen, 1'b1);
        chk("first_tick_latency", cnt_to_tick, OSR);

        // overdrive then return to zero
        do_reset(2);
        pcm = DW'(32767);
        pcm_valid = 1'b1;
        for (int i = 0; i < 2048; i++) step();
        pcm = '0;
        for (int i = 0; i < 256; i++) step();
        clr_stats();
        for (int i = 0; i < 256; i++) step();
        chk_range("overdrive_recovery_density", ones, 123, 133);

        // randomized traffic with gaps and data changing while waiting
        do_reset(2);
        pcm_valid = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0)
                pcm = DW'(int'($urandom_range(0, 49150)) - 24575);
            pcm_valid = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
